// File: rtl/map_rom_loader.sv
// Captures the MAP tile ROM window out of an ioctl ROM-image download and
// streams it into the tile ROM load port, tracking completeness and a checksum.
module map_rom_loader #(
   parameter logic [7:0]  ROM_INDEX   = 8'd0,
   parameter logic [24:0] REGION_BASE = 25'h0,
   parameter int          REGION_SIZE = 32768
) (
   input  logic        clk,
   input  logic        RESETn,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        bram_wr,
   output logic        bram_cs,
   output logic [19:0] bram_addr,
   output logic [7:0]  bram_data,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   localparam logic [20:0] SIZE_CNT   = 21'(REGION_SIZE);
   localparam logic [25:0] REGION_END = {1'b0, REGION_BASE} + 26'(REGION_SIZE);

   state_t      state;
   state_t      state_next;
   logic [20:0] count;
   logic [20:0] count_next;
   logic        armed;
   logic        in_window;
   logic        accept;
   logic        start;
   logic        finish;
   logic [19:0] rel_addr;

   assign in_window = ({1'b0, ioctl_addr} >= {1'b0, REGION_BASE}) &&
                      ({1'b0, ioctl_addr} < REGION_END);
   assign accept    = (state == LOAD) && ioctl_wr && in_window;
   assign finish    = (state == LOAD) && !ioctl_download;
   assign rel_addr  = 20'(ioctl_addr - REGION_BASE);

   // A download already in progress when reset lifts is not ours to join;
   // we only arm after having seen ioctl_download low at least once.
   assign start = (state != LOAD) && armed && ioctl_download &&
                  (ioctl_index == ROM_INDEX);

   // The coincident last byte is counted before the end-of-download decision.
   always_comb begin
      count_next = count;
      if (accept && (count != SIZE_CNT))
         count_next = count + 21'd1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_next = LOAD;
         LOAD: if (!ioctl_download)
                  state_next = (count_next == SIZE_CNT) ? DONE : ERR;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_next;
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) armed <= 1'b0;
      else if (!ioctl_download) armed <= 1'b1;
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         bram_wr   <= 1'b0;
         bram_addr <= '0;
         bram_data <= '0;
         count     <= '0;
         checksum  <= '0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         bram_wr <= accept;
         if (accept) begin
            bram_addr <= rel_addr;
            bram_data <= ioctl_dout;
         end
         if (start) begin
            count     <= '0;
            checksum  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
         end else begin
            count <= count_next;
            if (accept)
               checksum <= checksum + {8'h00, ioctl_dout};
            if (finish) begin
               load_done <= (count_next == SIZE_CNT);
               load_err  <= (count_next != SIZE_CNT);
            end
         end
      end
   end

   // The write strobe for a byte accepted on the last LOAD cycle lands in the
   // following state, so the select is held with it to keep that write valid.
   assign bram_cs = (state == LOAD) || bram_wr;

endmodule
